// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of a slow signal in system-clock cycles
module period_meter #(
  parameter int unsigned      WIDTH   = 28,
  parameter logic [WIDTH-1:0] TIMEOUT = 28'd200000000
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             signal_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;

  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic             fall;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] high_lat;

  logic             cnt_start;
  logic             cnt_step;
  logic             cnt_clear;
  logic             capture;
  logic             latch_high;
  logic             to_set;
  logic             to_clr;

  // Two-flop synchronizer followed by an edge register for edge detection
  always_ff @(posedge clock_in) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= signal_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // State register
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: arm on the first rise, fall back to idle when edges stop
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_next = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (!rise && (cnt == TIMEOUT)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath controls decoded from the current state and detected edges
  always_comb begin
    cnt_start  = 1'b0;
    cnt_step   = 1'b0;
    cnt_clear  = 1'b0;
    capture    = 1'b0;
    latch_high = 1'b0;
    to_set     = 1'b0;
    to_clr     = 1'b0;
    case (state)
      ST_IDLE: begin
        // No reference edge yet: counter parked at zero, falls ignored
        if (rise) begin
          cnt_start = 1'b1;
          to_clr    = 1'b1;
        end else begin
          cnt_clear = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          capture   = 1'b1;
          cnt_start = 1'b1;
        end else begin
          latch_high = fall;
          if (cnt == TIMEOUT) begin
            to_set    = 1'b1;
            cnt_clear = 1'b1;
          end else begin
            cnt_step = 1'b1;
          end
        end
      end
      default: cnt_clear = 1'b1;
    endcase
  end

  // Counter, high-time latch, result registers and status flags
  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt        <= '0;
      high_lat   <= '0;
      period_out <= '0;
      high_out   <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      valid <= capture;
      if (capture) begin
        period_out <= cnt;
        high_out   <= high_lat;
      end
      if (latch_high) begin
        high_lat <= cnt;
      end
      if (cnt_start) begin
        cnt <= CNT_ONE;
      end else if (cnt_clear) begin
        cnt <= '0;
      end else if (cnt_step) begin
        cnt <= cnt + CNT_ONE;
      end
      if (to_clr) begin
        timeout <= 1'b0;
      end else if (to_set) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule
